// File: rtl/chunked_mag_compare_if.sv
// Request/result bundle for the chunked magnitude comparator.
// The requester drives the operands and start; the comparator returns
// its handshake status and the registered compare result.
interface chunked_mag_compare_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             agreat;
  logic             bgreat;
  logic             aeb;

  modport master (
    output start,
    output signed_mode,
    output a,
    output b,
    input  busy,
    input  done,
    input  agreat,
    input  bgreat,
    input  aeb
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  a,
    input  b,
    output busy,
    output done,
    output agreat,
    output bgreat,
    output aeb
  );

endinterface

// File: rtl/chunked_mag_compare.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, CHUNK
// bits per clock, and stops at the first unequal chunk. Signed requests
// are mapped to offset-binary at load so the datapath is unsigned only.
// Results are registered and held until the next decision.
module chunked_mag_compare #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  chunked_mag_compare_if.slave bus
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_agreat;
  logic             r_bgreat;
  logic             r_aeb;

  logic [WIDTH-1:0] w_sa_load;
  logic [WIDTH-1:0] w_sb_load;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_chunk_eq;
  logic             w_chunk_agt;
  logic             w_accept;
  logic             w_decide;
  logic             w_busy;
  logic             w_done;

  // Top-chunk comparison, offset-binary load mapping and accept/decide strobes
  always_comb begin
    w_ca        = r_sa[WIDTH-1 -: CHUNK];
    w_cb        = r_sb[WIDTH-1 -: CHUNK];
    w_chunk_eq  = (w_ca == w_cb);
    w_chunk_agt = (w_ca > w_cb);
    // Flipping the sign bit turns two's complement ordering into unsigned ordering
    w_sa_load              = bus.a;
    w_sa_load[WIDTH-1]     = bus.a[WIDTH-1] ^ bus.signed_mode;
    w_sb_load              = bus.b;
    w_sb_load[WIDTH-1]     = bus.b[WIDTH-1] ^ bus.signed_mode;
    w_accept    = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // A decision is reached on the first unequal chunk or on the last chunk
    w_decide    = (r_state == ST_CMP) && (!w_chunk_eq || (r_cnt == CW'(0)));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_CMP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CMP: begin
        if (w_decide) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_CMP;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_state_nxt = ST_CMP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_CMP:  w_busy = 1'b1;
      ST_DONE: w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Operand shift registers and chunk counter: load on accept, shift while chunks match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa  <= {WIDTH{1'b0}};
      r_sb  <= {WIDTH{1'b0}};
      r_cnt <= CW'(0);
    end else if (w_accept) begin
      r_sa  <= w_sa_load;
      r_sb  <= w_sb_load;
      r_cnt <= CW'(N - 1);
    end else if ((r_state == ST_CMP) && !w_decide) begin
      r_sa  <= r_sa << CHUNK;
      r_sb  <= r_sb << CHUNK;
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_sa  <= r_sa;
      r_sb  <= r_sb;
      r_cnt <= r_cnt;
    end
  end

  // Result flags: updated only on the edge entering DONE, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_agreat <= 1'b0;
      r_bgreat <= 1'b0;
      r_aeb    <= 1'b0;
    end else if (w_decide) begin
      r_agreat <= !w_chunk_eq && w_chunk_agt;
      r_bgreat <= !w_chunk_eq && !w_chunk_agt;
      r_aeb    <= w_chunk_eq;
    end else begin
      r_agreat <= r_agreat;
      r_bgreat <= r_bgreat;
      r_aeb    <= r_aeb;
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = w_done;
  assign bus.agreat = r_agreat;
  assign bus.bgreat = r_bgreat;
  assign bus.aeb    = r_aeb;

endmodule

// File: doc/chunked_mag_compare.md
# chunked_mag_compare

Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands. It replaces the fixed 4-bit combinational comparator where operands are wide or timing is tight. Operands are compared MSB-first, CHUNK bits per clock, with early termination on the first unequal chunk. A start/busy/done handshake controls it, and a per-request signed/unsigned mode is selected at start. Results are registered and held for the downstream control logic.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH. Let N = WIDTH/CHUNK.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  in  WIDTH  operand A; sampled on acceptance.
- b  in  WIDTH  operand B; sampled on acceptance.
- busy  out  1  high while comparing.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- agreat  out  1  A > B.
- bgreat  out  1  B > A.
- aeb  out  1  A == B.

## Operation
- States are IDLE, CMP and DONE. busy = (state==CMP). done = (state==DONE).
- **Acceptance.** start=1 is accepted at an edge where state is IDLE or DONE. On acceptance:
  - a and b load into shift registers sa and sb.
  - Signed mode inverts the MSB of both operands at load (offset-binary), so the datapath compares unsigned only.
  - The chunk counter loads N-1.
  - state goes to CMP.
- **CMP cycle.** The datapath compares the top CHUNK bits of sa and sb.
  - Chunks unequal: agreat or bgreat is set to the chunk-wise comparison, aeb=0, and state goes to DONE.
  - Chunks equal and counter=0: aeb=1, agreat=bgreat=0, and state goes to DONE.
  - Chunks equal and counter>0: sa and sb shift left by CHUNK, the counter decrements, and state stays CMP.
- **DONE.** It lasts exactly one cycle. state goes back to IDLE, or to CMP if start=1 in that cycle.
- **Result outputs.** agreat, bgreat and aeb are registered. They change only at the edge entering DONE and otherwise hold their last value, including through IDLE and the next CMP. Exactly one of them is 1 after the first completed compare.
- **Ignored inputs.**
  - start while busy=1 is ignored and is not queued.
  - Changes on a, b or signed_mode after acceptance have no effect.
- **Reset.** rst_n=0 at any time, including mid-CMP, asynchronously forces:
  - state=IDLE;
  - busy=0, done=0;
  - agreat=bgreat=aeb=0;
  - counter and shift registers to 0.

  The in-flight compare is discarded. The first edge with rst_n=1 may accept start.

## Timing
- Start is accepted at edge E0. If the first unequal chunk is chunk j (j=1 = MSB chunk), the decision is registered at edge E0+j and done=1 during cycle E0+j.
- Latency runs from 1 cycle (MSB chunk differs) to N cycles (differ only in the last chunk, or equal).
- busy=1 from E0 up to the deciding edge. done and busy are never both 1.
- Back-to-back requests: start held high during DONE gives 1 dead cycle between requests. Continuous start gives throughput of one compare per j+1 cycles.
- CHUNK=WIDTH gives a fixed latency of 1. CHUNK=1 gives a bit-serial compare with latency up to WIDTH.
- No combinational path from inputs to outputs.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 (N=4).
- **Reset.** Assert rst_n=0 with no clock. Required: busy=done=agreat=bgreat=aeb=0 immediately.
- **MSB chunk differs.** Unsigned, a=0x8000, b=0x7FFF, start at E0. Required:
  - busy=1 for 1 cycle;
  - done at E0+1;
  - agreat=1, bgreat=0, aeb=0.
- **Equal operands.** a=b=0x1234. Required: done at E0+4, aeb=1. Also a=0x1235, b=0x1234: done at E0+4, agreat=1.
- **Signed mode.** signed_mode=1, a=0xFFFF, b=0x0001. Required: bgreat=1 at E0+1. Same operands with signed_mode=0: agreat=1. Also signed a=0x8000, b=0x7FFF: bgreat=1.
- **Handshake.**
  - Hold start=1 and change a/b every cycle during busy. Required: the result reflects only the sampled operands, and the extra start is ignored.
  - Assert start during DONE with new operands. Required: busy=1 the next cycle, and the prior result is held until the new done.
- **Reset mid-operation.** Pulse rst_n low during the 2nd CMP cycle of a=b=0xABCD. Required: immediate IDLE with outputs at 0, and no done pulse. A fresh start after release completes normally.
